// File: rtl/audio_frame_scheduler.sv
// Per-frame round-robin sample gatherer and saturating stereo mixer for the DAC.
// Optional macro MIX_ATTEN_EN: per-source arithmetic right shift (0..3) before mixing.
module audio_frame_scheduler #(
  parameter int N_SRC     = 4,
  parameter int SLOT_WAIT = 32,
  parameter int DW        = 16
) (
  input  logic                CLK_18_4,
  input  logic                RST_N,
  input  logic                AUD_LRCK,
  input  logic [N_SRC-1:0]    src_en,
  input  logic [N_SRC-1:0]    src_valid,
  input  logic [N_SRC*DW-1:0] src_left,
  input  logic [N_SRC*DW-1:0] src_right,
  output logic [N_SRC-1:0]    src_ready,
  input  logic [2*N_SRC-1:0]  src_atten,
  input  logic                clr_status,
  output logic [DW-1:0]       left_sample,
  output logic [DW-1:0]       right_sample,
  output logic                frame_tick,
  output logic                busy,
  output logic [N_SRC-1:0]    underrun,
  output logic                overrun,
  output logic [1:0]          state_dbg
);

  // Handshake: a sample pair transfers on any clock where src_valid[i] and
  // src_ready[i] are both high; src_ready is registered and one-hot.
  localparam int AW = DW + 3;
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int WW = $clog2(SLOT_WAIT + 1);
  localparam logic signed [AW-1:0] MAXV = $signed({{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}});
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE = 2'd0, GATHER = 2'd1, HOLD = 2'd2} state_t;
  state_t state, state_d;

  logic                 lrck_q, rise, fall;
  logic [IW-1:0]        idx;
  logic [N_SRC-1:0]     en_q, idx_oh;
  logic [WW-1:0]        wait_cnt;
  logic signed [AW-1:0] acc_l, acc_r;
  logic signed [DW-1:0] sel_l, sel_r, sh_l, sh_r;
  logic                 last;
  logic start, grant, waiting, xfer, tmo, adv, commit, abort, restart;

  assign rise      = AUD_LRCK & ~lrck_q;
  assign fall      = ~AUD_LRCK & lrck_q;
  assign last      = (idx == IW'(N_SRC - 1));
  assign idx_oh    = N_SRC'(1) << idx;
  assign busy      = (state == GATHER);
  assign state_dbg = state;
  assign sel_l     = src_left[idx*DW +: DW];
  assign sel_r     = src_right[idx*DW +: DW];

`ifdef MIX_ATTEN_EN
  assign sh_l = sel_l >>> src_atten[idx*2 +: 2];
  assign sh_r = sel_r >>> src_atten[idx*2 +: 2];
`else
  logic unused_atten;
  assign unused_atten = ^src_atten;
  assign sh_l = sel_l;
  assign sh_r = sel_r;
`endif

  function automatic logic [DW-1:0] sat(input logic signed [AW-1:0] a);
    if (a > MAXV)      return MAXV[DW-1:0];
    else if (a < MINV) return MINV[DW-1:0];
    else               return a[DW-1:0];
  endfunction

  always_comb begin
    state_d = state;
    start   = 1'b0;
    grant   = 1'b0;
    waiting = 1'b0;
    xfer    = 1'b0;
    tmo     = 1'b0;
    adv     = 1'b0;
    commit  = 1'b0;
    abort   = 1'b0;
    restart = 1'b0;
    case (state)
      IDLE: if (rise) begin
        start   = 1'b1;
        state_d = GATHER;
      end
      GATHER: begin
        if (fall) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          if (!en_q[idx])                         adv = 1'b1;
          else if (!src_ready[idx])               grant = 1'b1;
          else if (src_valid[idx])                begin xfer = 1'b1; adv = 1'b1; end
          else if (wait_cnt == WW'(SLOT_WAIT - 1)) begin tmo = 1'b1; adv = 1'b1; end
          else                                    waiting = 1'b1;
          if (adv && last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (fall) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else if (rise) begin
          // Only a corrupt LRCK gets here; start over and flag it.
          restart = 1'b1;
          start   = 1'b1;
          state_d = GATHER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_18_4 or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge CLK_18_4 or negedge RST_N) begin
    if (!RST_N) begin
      lrck_q       <= 1'b0;
      idx          <= '0;
      en_q         <= '0;
      wait_cnt     <= '0;
      acc_l        <= '0;
      acc_r        <= '0;
      src_ready    <= '0;
      left_sample  <= '0;
      right_sample <= '0;
      frame_tick   <= 1'b0;
      underrun     <= '0;
      overrun      <= 1'b0;
    end else begin
      lrck_q     <= AUD_LRCK;
      frame_tick <= commit;
      underrun   <= (underrun & ~{N_SRC{clr_status}}) | (tmo ? idx_oh : '0);
      overrun    <= (overrun & ~clr_status) | abort | restart;
      if (start) begin
        idx       <= '0;
        en_q      <= src_en;
        wait_cnt  <= '0;
        acc_l     <= '0;
        acc_r     <= '0;
        src_ready <= '0;
      end
      if (grant) begin
        src_ready <= idx_oh;
        wait_cnt  <= '0;
      end
      if (waiting) wait_cnt <= wait_cnt + 1'b1;
      if (xfer) begin
        acc_l <= acc_l + {{3{sh_l[DW-1]}}, sh_l};
        acc_r <= acc_r + {{3{sh_r[DW-1]}}, sh_r};
      end
      if (adv) begin
        src_ready <= '0;
        if (!last) idx <= idx + 1'b1;
      end
      if (abort) src_ready <= '0;
      if (commit) begin
        left_sample  <= sat(acc_l);
        right_sample <= sat(acc_r);
      end
    end
  end

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Directed bench for audio_frame_scheduler: 4 sources, SLOT_WAIT=100, LRCK half period 192 clocks.
module tb_audio_frame_scheduler;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int HALF = 192;
`ifdef MIX_ATTEN_EN
  localparam logic [15:0] ATT_L = 16'h1000;
  localparam logic [15:0] ATT_R = 16'hF000;
`else
  localparam logic [15:0] ATT_L = 16'h4000;
  localparam logic [15:0] ATT_R = 16'hC000;
`endif

  logic            CLK_18_4 = 1'b0;
  logic            RST_N = 1'b0;
  logic            AUD_LRCK = 1'b0;
  logic [N-1:0]    src_en = '0;
  logic [N-1:0]    src_valid = '0;
  logic [N*DW-1:0] src_left = '0;
  logic [N*DW-1:0] src_right = '0;
  logic [N-1:0]    src_ready;
  logic [2*N-1:0]  src_atten = '0;
  logic            clr_status = 1'b0;
  logic [DW-1:0]   left_sample, right_sample;
  logic            frame_tick, busy, overrun;
  logic [N-1:0]    underrun;
  logic [1:0]      state_dbg;

  int total = 0;
  int bad = 0;
  int ticks = 0;

  audio_frame_scheduler #(.N_SRC(N), .SLOT_WAIT(100), .DW(DW)) dut (
    .CLK_18_4(CLK_18_4), .RST_N(RST_N), .AUD_LRCK(AUD_LRCK),
    .src_en(src_en), .src_valid(src_valid), .src_left(src_left),
    .src_right(src_right), .src_ready(src_ready), .src_atten(src_atten),
    .clr_status(clr_status), .left_sample(left_sample), .right_sample(right_sample),
    .frame_tick(frame_tick), .busy(busy), .underrun(underrun), .overrun(overrun),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 CLK_18_4 = ~CLK_18_4;
  always @(negedge CLK_18_4) if (frame_tick === 1'b1) ticks++;

  // drivers
  task automatic set_all(input logic [15:0] l, input logic [15:0] r);
    for (int i = 0; i < N; i++) begin
      src_left[i*DW +: DW]  = l;
      src_right[i*DW +: DW] = r;
    end
  endtask

  task automatic do_frame();
    @(negedge CLK_18_4) AUD_LRCK = 1'b1;
    repeat (HALF) @(negedge CLK_18_4);
    AUD_LRCK = 1'b0;
    repeat (4) @(negedge CLK_18_4);
  endtask

  task automatic pulse_clr();
    @(negedge CLK_18_4) clr_status = 1'b1;
    @(negedge CLK_18_4) clr_status = 1'b0;
    @(negedge CLK_18_4);
  endtask

  task automatic test_reset();
    #2;
    total++; if (left_sample !== 16'h0) begin bad++; $display("FAIL reset_left got=%h exp=0000", left_sample); end
    total++; if (right_sample !== 16'h0) begin bad++; $display("FAIL reset_right got=%h exp=0000", right_sample); end
    total++; if (src_ready !== 4'h0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", src_ready); end
    total++; if ({frame_tick, busy, overrun} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {frame_tick, busy, overrun}); end
    total++; if (underrun !== 4'h0) begin bad++; $display("FAIL reset_underrun got=%b exp=0000", underrun); end
    repeat (3) @(negedge CLK_18_4);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK_18_4);
  endtask

  task automatic test_single();
    int t0;
    src_en = 4'b0001; src_valid = 4'b1111;
    set_all(16'h0000, 16'h0000);
    src_left[15:0] = 16'h1000; src_right[15:0] = 16'hF000;
    t0 = ticks;
    @(negedge CLK_18_4) AUD_LRCK = 1'b1;
    @(negedge CLK_18_4);
    total++; if (busy !== 1'b1 || src_ready !== 4'b0000) begin bad++; $display("FAIL single_start got busy=%b ready=%b exp busy=1 ready=0000", busy, src_ready); end
    @(negedge CLK_18_4);
    total++; if (src_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", src_ready); end
    @(negedge CLK_18_4);
    total++; if (src_ready !== 4'b0000) begin bad++; $display("FAIL single_drop got=%b exp=0000", src_ready); end
    repeat (HALF - 3) @(negedge CLK_18_4);
    total++; if (left_sample !== 16'h0000) begin bad++; $display("FAIL single_nocommit got=%h exp=0000", left_sample); end
    AUD_LRCK = 1'b0;
    repeat (4) @(negedge CLK_18_4);
    total++; if (left_sample !== 16'h1000 || right_sample !== 16'hF000) begin bad++; $display("FAIL single_mix got=%h/%h exp=1000/f000", left_sample, right_sample); end
    total++; if (ticks - t0 !== 1) begin bad++; $display("FAIL single_tick got=%0d exp=1", ticks - t0); end
    total++; if (overrun !== 1'b0 || underrun !== 4'h0 || busy !== 1'b0) begin bad++; $display("FAIL single_flags got ov=%b ur=%b busy=%b exp 0/0000/0", overrun, underrun, busy); end
  endtask

  task automatic test_saturation();
    src_en = 4'b1111; src_valid = 4'b1111;
    set_all(16'h3000, 16'h1000);
    do_frame();
    total++; if (left_sample !== 16'h7FFF || right_sample !== 16'h4000) begin bad++; $display("FAIL sat_pos got=%h/%h exp=7fff/4000", left_sample, right_sample); end
    set_all(16'hC000, 16'hFFFF);
    do_frame();
    total++; if (left_sample !== 16'h8000 || right_sample !== 16'hFFFC) begin bad++; $display("FAIL sat_neg got=%h/%h exp=8000/fffc", left_sample, right_sample); end
  endtask

  task automatic test_underrun();
    src_en = 4'b1111; src_valid = 4'b1011;
    set_all(16'h0100, 16'h0000);
    src_left[2*DW +: DW] = 16'h7000;
    for (int f = 0; f < 3; f++) begin
      do_frame();
      total++; if (left_sample !== 16'h0300) begin bad++; $display("FAIL underrun_mix frame=%0d got=%h exp=0300", f, left_sample); end
      total++; if (underrun !== 4'b0100 || overrun !== 1'b0) begin bad++; $display("FAIL underrun_flag frame=%0d got=%b ov=%b exp=0100 ov=0", f, underrun, overrun); end
    end
    pulse_clr();
    total++; if (underrun !== 4'b0000) begin bad++; $display("FAIL underrun_clr got=%b exp=0000", underrun); end
  endtask

  task automatic test_overrun();
    int t0;
    src_en = 4'b1111; src_valid = 4'b0000;
    t0 = ticks;
    do_frame();
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag got=%b exp=1", overrun); end
    total++; if (left_sample !== 16'h0300 || right_sample !== 16'h0000) begin bad++; $display("FAIL overrun_hold got=%h/%h exp=0300/0000", left_sample, right_sample); end
    total++; if (ticks - t0 !== 0) begin bad++; $display("FAIL overrun_tick got=%0d exp=0", ticks - t0); end
    total++; if (src_ready !== 4'h0 || busy !== 1'b0) begin bad++; $display("FAIL overrun_abort got ready=%b busy=%b exp 0000/0", src_ready, busy); end
    total++; if (underrun !== 4'b0001) begin bad++; $display("FAIL overrun_underrun got=%b exp=0001", underrun); end
    pulse_clr();
    total++; if (overrun !== 1'b0 || underrun !== 4'h0) begin bad++; $display("FAIL overrun_clr got ov=%b ur=%b exp 0/0000", overrun, underrun); end
  endtask

  task automatic test_reset_mid();
    int t0;
    src_en = 4'b1111; src_valid = 4'b0000;
    @(negedge CLK_18_4) AUD_LRCK = 1'b1;
    repeat (50) @(negedge CLK_18_4);
    total++; if (busy !== 1'b1 || src_ready !== 4'b0001) begin bad++; $display("FAIL midrst_pre got busy=%b ready=%b exp 1/0001", busy, src_ready); end
    #2 RST_N = 1'b0;
    #1;
    total++; if (src_ready !== 4'h0 || busy !== 1'b0 || left_sample !== 16'h0) begin bad++; $display("FAIL midrst_async got ready=%b busy=%b left=%h exp 0000/0/0000", src_ready, busy, left_sample); end
    AUD_LRCK = 1'b0;
    repeat (3) @(negedge CLK_18_4);
    RST_N = 1'b1;
    src_valid = 4'b1111;
    set_all(16'h0100, 16'h0010);
    t0 = ticks;
    do_frame();
    total++; if (left_sample !== 16'h0400 || right_sample !== 16'h0040) begin bad++; $display("FAIL midrst_frame got=%h/%h exp=0400/0040", left_sample, right_sample); end
    total++; if (ticks - t0 !== 1 || overrun !== 1'b0) begin bad++; $display("FAIL midrst_tick got ticks=%0d ov=%b exp 1/0", ticks - t0, overrun); end
  endtask

  task automatic test_atten();
    src_en = 4'b0001; src_valid = 4'b0001;
    set_all(16'h0000, 16'h0000);
    src_left[15:0] = 16'h4000; src_right[15:0] = 16'hC000;
    src_atten = 8'b11_11_11_10;
    do_frame();
    total++; if (left_sample !== ATT_L || right_sample !== ATT_R) begin bad++; $display("FAIL atten got=%h/%h exp=%h/%h", left_sample, right_sample, ATT_L, ATT_R); end
    src_atten = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_underrun();
    test_overrun();
    test_reset_mid();
    test_atten();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
